// File: rtl/can_rx_crc_check.sv
// CAN receive CRC-15 checker: runs the LFSR over SOF..data, then
// compares the 15 received CRC bits and reports pass/fail.
module can_rx_crc_check #(
  parameter int              CRC_W = 15,
  parameter logic [CRC_W-1:0] POLY = 15'h4599,
  parameter logic [CRC_W-1:0] INIT = 15'h7FFF,
  parameter int              LEN_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic [LEN_W-1:0] field_len,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             abort,
  output logic [CRC_W-1:0] crc_calc,
  output logic             busy,
  output logic             done,
  output logic             crc_ok,
  output logic             crc_err
);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    CRC
  } state_t;

  localparam logic [LEN_W-1:0] CRC_CNT = LEN_W'(CRC_W);

  state_t           state;
  logic [LEN_W-1:0] cnt;
  logic             mism;

  logic             nxt;
  logic [CRC_W-1:0] step;
  logic [3:0]       idx;
  logic             miss;

  assign nxt  = bit_in ^ crc_calc[CRC_W-1];
  assign step = {crc_calc[CRC_W-2:0], 1'b0} ^ (nxt ? POLY : '0);
  // counter runs 15..1 in CRC, so counter-1 selects MSB first
  assign idx  = cnt[3:0] - 4'd1;
  assign miss = bit_in ^ crc_calc[idx];
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      crc_calc <= INIT;
      cnt      <= '0;
      mism     <= 1'b0;
      done     <= 1'b0;
      crc_ok   <= 1'b0;
      crc_err  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state   <= IDLE;
        crc_ok  <= 1'b0;
        crc_err <= 1'b0;
      end else if (frame_start) begin
        crc_calc <= INIT;
        mism     <= 1'b0;
        crc_ok   <= 1'b0;
        crc_err  <= 1'b0;
        if (field_len == '0) begin
          state <= CRC;
          cnt   <= CRC_CNT;
        end else begin
          state <= DATA;
          cnt   <= field_len;
        end
      end else if (bit_valid) begin
        case (state)
          DATA: begin
            crc_calc <= step;
            if (cnt == LEN_W'(1)) begin
              cnt   <= CRC_CNT;
              state <= CRC;
            end else begin
              cnt <= cnt - LEN_W'(1);
            end
          end
          CRC: begin
            mism <= mism | miss;
            if (cnt == LEN_W'(1)) begin
              done    <= 1'b1;
              crc_ok  <= ~(mism | miss);
              crc_err <= mism | miss;
              state   <= IDLE;
            end else begin
              cnt <= cnt - LEN_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_can_rx_crc_check.sv
// Bench for can_rx_crc_check: table vectors, random frames against
// a polynomial-division model, and abort/restart/reset sequences.
module tb_can_rx_crc_check;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start;
  logic [6:0]  field_len;
  logic        bit_valid;
  logic        bit_in;
  logic        abort;
  logic [14:0] crc_calc;
  logic        busy;
  logic        done;
  logic        crc_ok;
  logic        crc_err;

  int checks = 0;
  int errors = 0;
  int dcnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (done) dcnt <= dcnt + 1;

  can_rx_crc_check dut (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .field_len(field_len), .bit_valid(bit_valid), .bit_in(bit_in),
    .abort(abort), .crc_calc(crc_calc), .busy(busy), .done(done),
    .crc_ok(crc_ok), .crc_err(crc_err)
  );

  typedef struct {
    string        name;
    int           len;
    logic [127:0] data;
    logic [14:0]  crcv;
    logic         exp_ok;
    logic [14:0]  exp_calc;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Remainder of the message polynomial (seeded with all ones) mod the
  // CAN generator, by long division on a 128-bit dividend.
  function automatic logic [14:0] model(input int len,
                                        input logic [127:0] data);
    logic [142:0] rem;
    logic [15:0]  gen;
    int           top;
    gen = 16'hC599;
    rem = '0;
    for (int i = 0; i < len; i++) rem[i + 15] = data[i];
    for (int i = 0; i < 15; i++) rem[len + i] = rem[len + i] ^ 1'b1;
    top = len + 14;
    for (int p = top; p >= 15; p--)
      if (rem[p])
        for (int k = 0; k < 16; k++) rem[p - 15 + k] ^= gen[k];
    return rem[14:0];
  endfunction

  task automatic send(input logic b, input int gap);
    repeat (gap) tick();
    bit_valid = 1'b1;
    bit_in    = b;
    tick();
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  task automatic start(input int len);
    frame_start = 1'b1;
    field_len   = 7'(len);
    tick();
    frame_start = 1'b0;
  endtask

  task automatic run_frame(input string nm, input int len,
                           input logic [127:0] data,
                           input logic [14:0] crcv, input int gmax,
                           input logic exp_ok,
                           input logic [14:0] exp_calc);
    int d0;
    d0 = dcnt;
    start(len);
    chk({nm, "_busy"}, busy, 1);
    chk({nm, "_clr"}, {crc_ok, crc_err}, 0);
    for (int i = len - 1; i >= 0; i--)
      send(data[i], $urandom_range(0, gmax));
    chk({nm, "_calc"}, crc_calc, exp_calc);
    for (int i = 14; i >= 0; i--) begin
      send(crcv[i], $urandom_range(0, gmax));
      if (i > 0 && done) chk({nm, "_early_done"}, done, 0);
    end
    chk({nm, "_done"}, done, 1);
    chk({nm, "_ok"}, crc_ok, exp_ok);
    chk({nm, "_err"}, crc_err, !exp_ok);
    tick();
    tick();
    chk({nm, "_pulses"}, dcnt - d0, 1);
    chk({nm, "_hold"}, {crc_ok, crc_err, busy}, {exp_ok, !exp_ok, 1'b0});
    chk({nm, "_frozen"}, crc_calc, exp_calc);
  endtask

  vec_t tbl[6];

  initial begin
    logic [127:0] d;
    logic [14:0]  c;
    int           fb;
    int           d0;

    rst = 1'b1; frame_start = 1'b0; field_len = '0;
    bit_valid = 1'b0; bit_in = 1'b0; abort = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_calc", crc_calc, 15'h7FFF);
    chk("rst_flags", {busy, done, crc_ok, crc_err}, 0);

    tbl[0] = '{"v0", 1, 128'd0, 15'h3A67, 1'b1, 15'h3A67};
    tbl[1] = '{"v1", 1, 128'd1, 15'h7FFE, 1'b1, 15'h7FFE};
    tbl[2] = '{"v2", 1, 128'd1, 15'h7FFF, 1'b0, 15'h7FFE};
    tbl[3] = '{"v3", 0, 128'd0, 15'h7FFF, 1'b1, 15'h7FFF};
    tbl[4] = '{"v4", 0, 128'd0, 15'h0000, 1'b0, 15'h7FFF};
    tbl[5] = '{"v5", 1, 128'd0, 15'h3A66, 1'b0, 15'h3A67};
    for (int i = 0; i < 6; i++)
      run_frame(tbl[i].name, tbl[i].len, tbl[i].data, tbl[i].crcv,
                0, tbl[i].exp_ok, tbl[i].exp_calc);

    // 83-bit standard frames with sparse bit_valid, good and corrupted
    for (int n = 0; n < 4; n++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      d[127:83] = '0;
      c = model(83, d);
      run_frame("rnd_good", 83, d, c, 3, 1'b1, c);
      fb = $urandom_range(0, 82);
      d[fb] = ~d[fb];
      run_frame("rnd_bad", 83, d, c, 3, 1'b0, model(83, d));
    end

    // abort at the 7th CRC bit
    d0 = dcnt;
    start(1);
    send(1'b0, 0);
    for (int i = 14; i >= 8; i--) send(tbl[0].crcv[i], 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_state", {busy, done, crc_ok, crc_err}, 0);
    chk("abort_lfsr", crc_calc, 15'h3A67);
    for (int i = 7; i >= 0; i--) send(tbl[0].crcv[i], 0);
    tick();
    chk("abort_nodone", dcnt - d0, 0);

    // restart mid-DATA with a simultaneous bit that must be dropped
    d0 = dcnt;
    start(5);
    send(1'b1, 0);
    send(1'b0, 0);
    frame_start = 1'b1; field_len = 7'd1; bit_valid = 1'b1; bit_in = 1'b1;
    tick();
    frame_start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    chk("restart_seed", crc_calc, 15'h7FFF);
    chk("restart_busy", busy, 1);
    send(1'b0, 0);
    chk("restart_calc", crc_calc, 15'h3A67);
    for (int i = 14; i >= 0; i--) send(tbl[0].crcv[i], 0);
    chk("restart_ok", {done, crc_ok, crc_err}, 3'b110);
    tick();
    chk("restart_pulses", dcnt - d0, 1);

    // reset during CRC phase, then stray bits in IDLE
    start(1);
    send(1'b1, 0);
    for (int i = 14; i >= 10; i--) send(1'b1, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_flags", {busy, done, crc_ok, crc_err}, 0);
    chk("midrst_calc", crc_calc, 15'h7FFF);
    for (int i = 0; i < 20; i++) send(1'($urandom), 0);
    chk("idle_calc", crc_calc, 15'h7FFF);
    chk("idle_flags", {busy, done, crc_ok, crc_err}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/can_rx_crc_check.md
Name: can_rx_crc_check

Overview:
- Receive-side CRC-15 checker for the CAN controller, the counterpart of the transmit-side CRC generator.
- Consumes destuffed received bits one per `bit_valid` strobe, MSB-first as they appear on the bus.
- Runs the CAN CRC-15 LFSR over the protected field (SOF through end of data), then compares the following 15 received CRC bits against the computed value.
- Reports pass/fail to the receive FSM before the CRC delimiter.

Parameters:
- CRC_W, 15, CRC register width (fixed for CAN; not intended to be overridden).
- POLY, 15'h4599, generator x^15+x^14+x^10+x^8+x^7+x^4+x^3+1 (x^15 implicit).
- INIT, 15'h7FFF, LFSR seed loaded at frame start; matches the transmit generator's all-ones seed.
- LEN_W, 7, width of field_len (max protected field 127 bits).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle pulse: seed LFSR, latch field_len, enter DATA.
- field_len  in  LEN_W  number of protected bits before the CRC field; sampled only on frame_start.
- bit_valid  in  1  qualifies bit_in; at most one bit is consumed per cycle.
- bit_in  in  1  destuffed received bit.
- abort  in  1  error frame or bus-off: return to IDLE silently.
- crc_calc  out  CRC_W  current LFSR contents; frozen after DATA completes.
- busy  out  1  high in DATA or CRC state.
- done  out  1  one-cycle pulse when the 15th CRC bit is consumed.
- crc_ok  out  1  held high after done if all 15 bits matched; cleared on frame_start, abort or rst.
- crc_err  out  1  held high after done if any bit mismatched; same clearing rules as crc_ok.

Behaviour:
- States: IDLE, DATA, CRC. Encoding is free.
- Reset:
  - state=IDLE, LFSR=INIT.
  - bit counter=0.
  - busy=0, done=0, crc_ok=0, crc_err=0, mismatch flag=0.
- LFSR step, on each consumed bit in DATA:
  - nxt = bit_in ^ crc[14].
  - crc <= {crc[13:0],1'b0} ^ (nxt ? POLY : 0).
- IDLE:
  - bit_valid is ignored.
  - On frame_start: LFSR<=INIT, counter<=field_len, clear crc_ok, crc_err and the mismatch flag.
  - Next state is DATA, or CRC directly if field_len==0.
- DATA:
  - Each bit_valid steps the LFSR and decrements the counter.
  - When the bit that takes the counter 1->0 is consumed: freeze LFSR, load counter=15, go to CRC the next cycle.
- CRC:
  - Each bit_valid compares bit_in with crc_calc[counter-1] (MSB first, crc_calc[14] first).
  - Any mismatch sets the sticky mismatch flag. The LFSR does not step.
  - On the 15th bit: done=1 for one cycle; crc_ok=~mismatch and crc_err=mismatch (including the current bit); state=IDLE.
- Latency: done, crc_ok and crc_err assert in the cycle after the clock edge that samples the last CRC bit.
- Bits are not required on consecutive cycles; gaps on bit_valid hold all state.
- Priority: rst > abort > frame_start > bit_valid.
- frame_start while busy restarts the check cleanly. No done is issued for the discarded frame. A bit_valid in the same cycle is ignored.
- abort in any state: state=IDLE, done=0, crc_ok=0, crc_err=0. The LFSR is left as is.
- rst mid-frame: full reset values next cycle.
- crc_ok and crc_err are never high simultaneously. Both are 0 while busy.

Test Plan:
- field_len=1, bit 0, then CRC bits of 15'h3A67 MSB-first -> crc_calc=3A67 after DATA; done pulse; crc_ok=1, crc_err=0.
- field_len=1, bit 1, then CRC 15'h7FFE -> crc_ok=1. Repeat with CRC 15'h7FFF (LSB flipped) -> crc_err=1, crc_ok=0, done still exactly one pulse after 15 bits.
- field_len=0, CRC 15'h7FFF -> immediate CRC phase, crc_ok=1. With CRC 15'h0000 -> crc_err=1.
- Full 83-bit standard frame from a reference model, bit_valid every 3rd cycle with random gaps; also corrupt one data bit -> correct frame gives crc_ok; corrupted frame gives crc_err. crc_calc matches the model after bit 83.
- abort asserted at CRC bit 7 -> IDLE next cycle, no done, crc_ok=crc_err=0. frame_start mid-DATA with simultaneous bit_valid -> LFSR=7FFF, counter reloaded, that bit not consumed.
- rst asserted during CRC phase -> all outputs 0, state IDLE. bit_valid pulses while IDLE leave crc_calc=7FFF unchanged.
